// File: rtl/pipe_skid_reg.sv
// Ready/valid pipeline register with a 2-entry skid buffer, synchronous flush and a
// saturating stall-cycle counter. Every output comes straight from a flop.
module pipe_skid_reg #(
    parameter int PAYLOAD_W = 32,
    parameter bit CLR_ZERO  = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occ,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                state_q, state_d;
    logic [PAYLOAD_W-1:0]  main_q, main_d;
    logic [PAYLOAD_W-1:0]  skid_q, skid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [1:0]            occ_q, occ_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  push;
    logic                  pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // Flush wins over any handshake in the same cycle; the skid entry refills main on a FULL pop.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (clr) begin
            state_d = EMPTY;
            if (CLR_ZERO) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        occ_d       = 2'd0;
        case (state_d)
            ONE: begin
                out_valid_d = 1'b1;
                occ_d       = 2'd1;
            end
            FULL: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                occ_d       = 2'd2;
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                occ_d       = 2'd0;
            end
        endcase
    end

    // A flush cycle never counts as a stall, but the flush itself leaves the count alone.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid_q && !out_ready && !clr && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occ       = occ_q;
    assign stall_cnt = cnt_q;

endmodule
